// File: rtl/ils_pkg.sv
// Shared types and defaults for the image load sequencer: FSM state encoding,
// default parameter values and counter width helper.
package ils_pkg;

  localparam int ILS_DATA_W     = 32;
  localparam int ILS_CNT_W      = 16;
  localparam int ILS_GAP_CYCLES = 2;
  localparam int ILS_TIMEOUT    = 255;

  typedef logic [ILS_CNT_W-1:0] ils_cnt_t;

  typedef enum logic [3:0] {
    S_IDLE, S_TRIG, S_WAIT_REQ, S_WAIT_END, S_SETTLE, S_PUSH, S_GAP, S_DONE, S_ERR
  } ils_state_e;

  // Counters are loaded with (cycles-1), so they only need to hold maxVal-1.
  function automatic int ilsCtrW(input int maxVal);
    return (maxVal > 1) ? $clog2(maxVal) : 1;
  endfunction

endpackage

// File: rtl/ils_timeout_ctr.sv
// Loadable down-counter; oExpired is high whenever the count sits at zero.
// Clear wins over load, load wins over decrement.
module ils_timeout_ctr #(
  parameter int W = 8
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iClear,
  input  logic         iLoad,
  input  logic [W-1:0] iLoadVal,
  input  logic         iEn,
  output logic         oExpired
);

  logic [W-1:0] cnt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                     cnt <= '0;
    else if (iClear)              cnt <= '0;
    else if (iLoad)               cnt <= iLoadVal;
    else if (iEn && cnt != '0)    cnt <= cnt - W'(1);
  end

  assign oExpired = (cnt == '0);

endmodule

// File: rtl/image_load_sequencer.sv
// Drives the bit queuer one word at a time for HPS image loads and hands the
// assembled words downstream over valid/ready. ILS_CHECKSUM_EN adds oChecksum.
module image_load_sequencer
  import ils_pkg::*;
#(
  parameter int DATA_W     = ILS_DATA_W,
  parameter int CNT_W      = ILS_CNT_W,
  parameter int GAP_CYCLES = ILS_GAP_CYCLES,
  parameter int TIMEOUT    = ILS_TIMEOUT
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic [CNT_W-1:0]  iNumWords,
  input  logic              iAbort,
  output logic              oQ_TRIG,
  input  logic              iQ_REQ,
  input  logic [DATA_W-1:0] iQ_DATA,
  output logic [DATA_W-1:0] oWord,
  output logic              oWordValid,
  input  logic              iWordReady,
  output logic [CNT_W-1:0]  oWordCount,
  output logic              oBusy,
  output logic              oDone,
`ifdef ILS_CHECKSUM_EN
  output logic              oError,
  output logic [DATA_W-1:0] oChecksum
`else
  output logic              oError
`endif
);

  localparam int TMO_W = ilsCtrW(TIMEOUT);
  localparam int GAP_W = ilsCtrW(GAP_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  ils_state_e       state, nxt;
  logic [CNT_W-1:0] numWords, cntInc;
  logic             ctrClear, tmoLoad, tmoEn, tmoExp, gapLoad, gapEn, gapExp;
  logic             startOk, capture, accept;

  assign cntInc = oWordCount + CNT_W'(1);

  ils_timeout_ctr #(.W(TMO_W)) uTmo (
    .iCLK(iCLK), .iRST(iRST), .iClear(ctrClear), .iLoad(tmoLoad),
    .iLoadVal(TMO_LOAD), .iEn(tmoEn), .oExpired(tmoExp)
  );

  ils_timeout_ctr #(.W(GAP_W)) uGap (
    .iCLK(iCLK), .iRST(iRST), .iClear(ctrClear), .iLoad(gapLoad),
    .iLoadVal(GAP_LOAD), .iEn(gapEn), .oExpired(gapExp)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt      = state;
    ctrClear = 1'b0;
    tmoLoad  = 1'b0;
    tmoEn    = 1'b0;
    gapLoad  = 1'b0;
    gapEn    = 1'b0;
    startOk  = 1'b0;
    capture  = 1'b0;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        ctrClear = 1'b1;
        if (iStart && !iAbort) begin
          startOk = 1'b1;
          nxt     = (iNumWords == '0) ? S_DONE : S_TRIG;
        end
      end
      S_TRIG: begin
        tmoLoad = 1'b1;
        nxt     = S_WAIT_REQ;
      end
      S_WAIT_REQ: begin
        if (iQ_REQ) begin
          tmoLoad = 1'b1;
          nxt     = S_WAIT_END;
        end else if (tmoExp) nxt = S_ERR;
        else                 tmoEn = 1'b1;
      end
      S_WAIT_END: begin
        if (!iQ_REQ)     nxt = S_SETTLE;
        else if (tmoExp) nxt = S_ERR;
        else             tmoEn = 1'b1;
      end
      S_SETTLE: begin
        capture = 1'b1;
        nxt     = S_PUSH;
      end
      S_PUSH: begin
        if (iWordReady) begin
          accept = 1'b1;
          if (cntInc == numWords)  nxt = S_DONE;
          else if (GAP_CYCLES == 0) nxt = S_TRIG;
          else begin
            gapLoad = 1'b1;
            nxt     = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gapExp) nxt = S_TRIG;
        else        gapEn = 1'b1;
      end
      S_DONE:  nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    // Abort freezes everything: no capture, no count, straight back to IDLE.
    if (state != S_IDLE && iAbort) begin
      nxt     = S_IDLE;
      capture = 1'b0;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      numWords   <= '0;
      oWordCount <= '0;
      oWord      <= '0;
      oError     <= 1'b0;
    end else begin
      if (startOk) begin
        numWords   <= iNumWords;
        oWordCount <= '0;
        oError     <= 1'b0;
      end
      if (capture)      oWord      <= iQ_DATA;
      if (accept)       oWordCount <= cntInc;
      if (nxt == S_ERR) oError     <= 1'b1;
    end
  end

`ifdef ILS_CHECKSUM_EN
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)         oChecksum <= '0;
    else if (startOk) oChecksum <= '0;
    else if (accept)  oChecksum <= oChecksum ^ oWord;
  end
`else
`endif

  assign oQ_TRIG    = (state == S_TRIG);
  assign oWordValid = (state == S_PUSH);
  assign oBusy      = (state != S_IDLE);
  assign oDone      = (state == S_DONE) && !iAbort;

endmodule
